// File: rtl/divider16by8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional busy output OCUPADO is enabled by defining DIVIDER16BY8_BUSY_EN.
module divider16by8_seq #(
   parameter int N_DIVIDEND = 16,
   parameter int N_DIVISOR  = 8
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  S,
   input  logic [N_DIVIDEND-1:0] n,
   input  logic [N_DIVISOR-1:0]  d,
   output logic [N_DIVIDEND-1:0] q,
   output logic [N_DIVISOR-1:0]  r,
   output logic                  DIV0,
   output logic                  PRONTO
`ifdef DIVIDER16BY8_BUSY_EN
   ,
   output logic                  OCUPADO
`endif
);

   localparam int CW = $clog2(N_DIVIDEND);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                r_state;
   logic [N_DIVIDEND-1:0] r_n;
   logic [N_DIVISOR-1:0]  r_d;
   logic [N_DIVISOR:0]    r_p;
   logic [CW-1:0]         r_cnt;
   logic [N_DIVIDEND-1:0] r_q;
   logic [N_DIVISOR-1:0]  r_r;
   logic                  r_div0;
   logic                  r_pronto;
   logic                  r_ocupado;

   logic [N_DIVISOR:0]    w_t;
   logic                  w_ge;
   logic [N_DIVISOR:0]    w_p_next;
   logic [N_DIVIDEND-1:0] w_n_next;

   // One restoring step; r_n shifts the dividend out and the quotient in from the LSB.
   always_comb begin
      w_t      = {r_p[N_DIVISOR-1:0], r_n[N_DIVIDEND-1]};
      w_ge     = (w_t >= {1'b0, r_d});
      w_p_next = w_ge ? (w_t - {1'b0, r_d}) : w_t;
      w_n_next = {r_n[N_DIVIDEND-2:0], w_ge};
   end

   // Control FSM and datapath registers; every output comes straight from a flop.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= IDLE;
         r_n       <= {N_DIVIDEND{1'b0}};
         r_d       <= {N_DIVISOR{1'b0}};
         r_p       <= {(N_DIVISOR+1){1'b0}};
         r_cnt     <= {CW{1'b0}};
         r_q       <= {N_DIVIDEND{1'b0}};
         r_r       <= {N_DIVISOR{1'b0}};
         r_div0    <= 1'b0;
         r_pronto  <= 1'b0;
         r_ocupado <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_pronto <= 1'b0;
               if (S) begin
                  r_state   <= LOAD;
                  r_ocupado <= 1'b1;
               end else begin
                  r_state   <= IDLE;
                  r_ocupado <= 1'b0;
               end
            end
            LOAD: begin
               r_n   <= n;
               r_d   <= d;
               r_p   <= {(N_DIVISOR+1){1'b0}};
               r_cnt <= {CW{1'b0}};
               if (d == {N_DIVISOR{1'b0}}) begin
                  r_q       <= {N_DIVIDEND{1'b1}};
                  r_r       <= n[N_DIVISOR-1:0];
                  r_div0    <= 1'b1;
                  r_pronto  <= 1'b1;
                  r_ocupado <= 1'b0;
                  r_state   <= DONE;
               end else begin
                  r_div0  <= 1'b0;
                  r_state <= DIV;
               end
            end
            DIV: begin
               r_n   <= w_n_next;
               r_p   <= w_p_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(N_DIVIDEND - 1)) begin
                  r_q       <= w_n_next;
                  r_r       <= w_p_next[N_DIVISOR-1:0];
                  r_pronto  <= 1'b1;
                  r_ocupado <= 1'b0;
                  r_state   <= DONE;
               end else begin
                  r_state <= DIV;
               end
            end
            DONE: begin
               r_pronto <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_pronto  <= 1'b0;
               r_ocupado <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign q      = r_q;
   assign r      = r_r;
   assign DIV0   = r_div0;
   assign PRONTO = r_pronto;
`ifdef DIVIDER16BY8_BUSY_EN
   assign OCUPADO = r_ocupado;
`else
   logic w_unused;
   assign w_unused = r_ocupado;
`endif

endmodule

// File: tb/tb_divider16by8_seq.sv
// Directed scoreboard bench for divider16by8_seq; the monitor pops expected results on PRONTO.
module tb_divider16by8_seq;

   logic        CLK;
   logic        RESET_N;
   logic        S;
   logic [15:0] n;
   logic [7:0]  d;
   logic [15:0] q;
   logic [7:0]  r;
   logic        DIV0;
   logic        PRONTO;
`ifdef DIVIDER16BY8_BUSY_EN
   logic        OCUPADO;
`endif

   divider16by8_seq dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .S       (S),
      .n       (n),
      .d       (d),
      .q       (q),
      .r       (r),
      .DIV0    (DIV0),
`ifdef DIVIDER16BY8_BUSY_EN
      .OCUPADO (OCUPADO),
`endif
      .PRONTO  (PRONTO)
   );

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic        div0;
      int          cyc;
      bit          exact;
   } exp_t;

   exp_t sb[$];
   int   n_asserts = 0;
   int   n_fail    = 0;
   int   cyc       = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic push(input logic [15:0] nv, input logic [7:0] dv, input int ecyc, input bit exact);
      exp_t e;
      if (dv == 8'd0) begin
         e.q = 16'hFFFF; e.r = nv[7:0]; e.div0 = 1'b1;
      end else begin
         e.q = nv / {8'd0, dv}; e.r = 8'(nv % {8'd0, dv}); e.div0 = 1'b0;
      end
      e.cyc = ecyc;
      e.exact = exact;
      sb.push_back(e);
   endtask

   // Drive one start pulse at a negedge; n/d are held through the following LOAD edge.
   task automatic start_op(input logic [15:0] nv, input logic [7:0] dv);
      n = nv; d = dv; S = 1'b1;
      if (dv == 8'd0) push(nv, dv, cyc + 3, 1'b0);
      else            push(nv, dv, cyc + 18, 1'b1);
      tick();
      S = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      chk("drain", sb.size(), 0);
      sb.delete();
      tick();
      tick();
   endtask

   // Monitor: checks each PRONTO pulse against the scoreboard head.
   initial begin
      logic prev_pronto;
      exp_t e;
      prev_pronto = 1'b0;
      forever begin
         @(negedge CLK);
         if (PRONTO) begin
            chk("pronto_width", prev_pronto, 0);
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("q", q, e.q);
               chk("r", r, e.r);
               chk("div0", DIV0, e.div0);
               if (e.exact) chk("latency", cyc, e.cyc);
               else         chk("latency_max", cyc <= e.cyc, 1);
            end
         end
         prev_pronto = PRONTO;
      end
   end

   initial begin
      int c;
      int occ;
      RESET_N = 1'b0; S = 1'b0; n = 16'd0; d = 8'd0;
      tick();
      tick();
      chk("rst_q", q, 0);
      chk("rst_r", r, 0);
      chk("rst_div0", DIV0, 0);
      chk("rst_pronto", PRONTO, 0);
      RESET_N = 1'b1;
      tick();

      start_op(16'd1000, 8'd7);
      wait_idle();
      chk("hold_q_1000_7", q, 16'd142);
      chk("hold_r_1000_7", r, 8'd6);

      start_op(16'd65535, 8'd255);
      wait_idle();
      start_op(16'd65535, 8'd1);
      wait_idle();
      start_op(16'd5, 8'd9);
      wait_idle();
      start_op(16'd100, 8'd0);
      wait_idle();
      chk("hold_q_div0", q, 16'hFFFF);
      chk("hold_r_div0", r, 8'h64);
      chk("hold_div0", DIV0, 1);
      start_op(16'd40000, 8'd200);
      wait_idle();
      chk("div0_cleared", DIV0, 0);

      // S pulsed again while busy must be ignored.
      start_op(16'd1000, 8'd7);
      tick(); tick(); tick();
      n = 16'd9; d = 8'd3; S = 1'b1;
      tick();
      S = 1'b0;
      wait_idle();
      chk("busy_q", q, 16'd142);

      // Asynchronous reset mid-division aborts without a result.
      start_op(16'd1000, 8'd7);
      repeat (6) tick();
      #2 RESET_N = 1'b0;
      #1;
      chk("abort_q", q, 0);
      chk("abort_r", r, 0);
      chk("abort_pronto", PRONTO, 0);
      sb.delete();
      tick();
      tick();
      chk("abort_pronto_held", PRONTO, 0);
      RESET_N = 1'b1;
      tick();
      start_op(16'd21, 8'd4);
      wait_idle();
      chk("post_reset_q", q, 16'd5);

      // S held high: back-to-back operations every 19 cycles.
      c = cyc;
      n = 16'd300; d = 8'd16; S = 1'b1;
      for (int i = 0; i < 4; i++) push(16'd300, 8'd16, c + 18 + 19 * i, 1'b1);
      occ = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
`ifdef DIVIDER16BY8_BUSY_EN
         if (i < 57) occ += int'(OCUPADO);
`endif
      end
      S = 1'b0;
      wait_idle();
`ifdef DIVIDER16BY8_BUSY_EN
      chk("ocupado_count", occ, 51);
      chk("ocupado_idle", OCUPADO, 0);
`endif
      chk("stream_r", r, 8'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
